// File: rtl/frame_deinterleave.sv
// Collects NCH interleaved channel samples (tagged by s_axis_tid) into one packed frame.
// Out-of-order tids abort the partial frame and raise a one-cycle err pulse.
module frame_deinterleave #(
    parameter int DW   = 24,
    parameter int NCH  = 2,
    parameter int TIDW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [TIDW-1:0]   s_axis_tid,
    output logic [NCH*DW-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              err
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0]     exp;
    logic [NCH*DW-1:0] acc;
    logic [NCH*DW-1:0] acc_w;
    logic              pend;
    logic              in_hs;
    logic              hit;
    logic              miss;
    logic              restart;
    logic              last;
    logic              complete;
    logic              out_free;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and ready here depends only on
    // registered state (pend) and rst, never on m_axis_tready.
    assign s_axis_tready = !pend && !rst;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign out_free      = !m_axis_tvalid || m_axis_tready;

    assign hit      = in_hs && (s_axis_tid == TIDW'(exp));
    assign miss     = in_hs && !hit;
    assign restart  = miss && (s_axis_tid == '0);
    assign last     = (exp == CW'(NCH - 1));
    assign complete = (hit && last) || (restart && (NCH == 1));

    // acc_w is the accumulator as it will look after this cycle's sample; on
    // completion it is exactly the finished frame.
    always_comb begin
        acc_w = acc;
        if (hit) begin
            acc_w[exp*DW +: DW] = s_axis_tdata;
        end else if (restart) begin
            acc_w[DW-1:0] = s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp           <= '0;
            acc           <= '0;
            pend          <= 1'b0;
            err           <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            err <= miss;

            if (in_hs) begin
                acc <= acc_w;
                if (hit && !last) begin
                    exp <= exp + CW'(1);
                end else if (restart && (NCH > 1)) begin
                    exp <= CW'(1);
                end else begin
                    exp <= '0;
                end
            end

            // pend and complete are mutually exclusive: pend blocks s_axis_tready.
            if (pend && out_free) begin
                m_axis_tdata  <= acc;
                m_axis_tvalid <= 1'b1;
                pend          <= 1'b0;
            end else if (complete && out_free) begin
                m_axis_tdata  <= acc_w;
                m_axis_tvalid <= 1'b1;
            end else if (complete) begin
                pend <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frame_deinterleave.md
FRAME_DEINTERLEAVE -- requirements
Module: frame_deinterleave

Interface
REQ-001 SHALL have parameter DW, default 24: sample width in bits.
REQ-002 SHALL have parameter NCH, default 2: channels per frame, legal range 1 to 2**TIDW.
REQ-003 SHALL have parameter TIDW, default 8: tid width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port s_axis_tdata, input, DW bits: interleaved sample.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: input sample valid.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: input ready.
REQ-009 SHALL have port s_axis_tid, input, TIDW bits: channel index of the sample.
REQ-010 SHALL have port m_axis_tdata, output, NCH*DW bits: packed frame.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: frame valid.
REQ-012 SHALL have port m_axis_tready, input, 1 bit: frame accepted.
REQ-013 SHALL have port err, output, 1 bit: one-cycle sequence-error pulse.

Function
REQ-014 SHALL define a handshake as valid && ready high at a rising edge, on either port.
REQ-015 SHALL keep an expected-channel counter exp (range 0..NCH-1) and NCH accumulation slots, acc[0..NCH-1].
REQ-016 SHALL, on an input handshake where tid == exp and exp < NCH-1, store the data in acc[exp] and increment exp.
REQ-017 SHALL, on an input handshake where tid == exp == NCH-1, complete the frame and set exp to 0.
REQ-018 SHALL pack completed frames with channel k at m_axis_tdata[k*DW +: DW], so channel 0 occupies the LSBs.
REQ-019 SHALL, on completion when the output register is free (!m_axis_tvalid || m_axis_tready), load the frame into the output register and assert m_axis_tvalid on the next cycle; latency is 1 cycle from the last-sample handshake.
REQ-020 SHALL, on completion when the output register is occupied and stalled, hold the frame in acc and set a pend flag.
REQ-021 SHALL drive s_axis_tready = !pend && !rst, with no combinational path from m_axis_tready to s_axis_tready.
REQ-022 SHALL, while pend is set and the output register is free, move acc to the output register, clear pend, and assert m_axis_tvalid on the next cycle.
REQ-023 SHALL clear m_axis_tvalid after an output handshake unless a new frame loads in the same cycle.
REQ-024 SHALL hold m_axis_tdata stable while m_axis_tvalid && !m_axis_tready.
REQ-025 SHALL sustain one sample per cycle when m_axis_tready is held high, with no bubbles at frame boundaries.
REQ-026 SHALL, on a mismatched handshake (tid != exp) with tid == 0, discard the partial frame, store the data in acc[0], and set exp to 1 (or complete the frame if NCH == 1).
REQ-027 SHALL, on a mismatched handshake with tid != 0 (including tid >= NCH), discard both the sample and the partial frame and set exp to 0.
REQ-028 SHALL pulse err high for exactly one cycle, the cycle after any mismatched handshake.
REQ-029 SHALL, when NCH == 1, treat every tid-0 sample as a complete frame, and every nonzero tid as an error.
REQ-030 SHALL never let a mismatch affect a frame already in the output register or in pend.

Reset
REQ-031 SHALL, while rst is high, hold m_axis_tvalid=0, m_axis_tdata=0, err=0, pend=0, exp=0, and s_axis_tready=0.
REQ-032 SHALL present s_axis_tready=1 in the first cycle after rst deasserts.
REQ-033 SHALL give reset priority over all same-cycle handshakes.
REQ-034 SHALL discard any partial frame, pending frame, or output frame on reset.

Verification (NCH=2, DW=24)
REQ-035 SHALL cover: tid0=0x000001 then tid1=0x000002 with m_axis_tready=1 -> m_axis_tdata=0x000002000001 and m_axis_tvalid high 1 cycle after the second handshake; err=0.
REQ-036 SHALL cover: m_axis_tready=0, 4 back-to-back samples forming frames A and B -> A held on output, s_axis_tready=0 after the 4th handshake; raise m_axis_tready -> A then B delivered on consecutive cycles, and s_axis_tready=1 the cycle after B is loaded.
REQ-037 SHALL cover: tids 0(0xA),0(0xB),1(0xC) -> single err pulse after the 2nd handshake; output frame 0x00000C00000B.
REQ-038 SHALL cover: tid 1 as the first sample -> sample dropped and err pulse; a following 0,1 pair gives a normal frame.
REQ-039 SHALL cover: tid 5 after tid 0 -> err pulse, exp=0, no output; the next 0,1 pair gives a correct frame.
REQ-040 SHALL cover: rst asserted one cycle after a tid-0 handshake, and after release tid 1 -> err pulse, no stale frame; m_axis_tvalid stays 0.
